mem_arbiter: RTL

- Two-requester arbiter sharing the single-port SoC RAM between the processor (port 0) and a second master (port 1: UART program loader or DMA).
- Sits between the masters and the Memory block, and sequences each access as an issue cycle followed by a fixed read-latency wait.
- Fairness is round-robin, so neither master can starve the other.

---
 rtl/mem_arbiter.sv | 108 ++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter granting one of two masters access to the single-port RAM.
// Each access is an issue cycle, followed for reads by a fixed LAT-cycle wait.
module mem_arbiter #(
  parameter int unsigned LAT = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wmask,
  output logic [31:0] m0_rdata,
  output logic        m0_rvalid,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wmask,
  output logic [31:0] m1_rdata,
  output logic        m1_rvalid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  output logic        mem_rstrb,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam logic [1:0] LAT_CNT = 2'(LAT);

  state_t      state;
  logic        last_grant;
  logic        port;
  logic [1:0]  cnt;
  logic        winner;
  logic        req_any;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_wmask;

  always_comb begin
    winner = 1'b0;
    if (m0_valid && m1_valid) winner = ~last_grant;
    else if (m1_valid)        winner = 1'b1;
  end

  assign req_any   = m0_valid | m1_valid;
  assign sel_addr  = winner ? m1_addr  : m0_addr;
  assign sel_wdata = winner ? m1_wdata : m0_wdata;
  assign sel_wmask = winner ? m1_wmask : m0_wmask;

  assign m0_ready = (state == IDLE) && m0_valid && !winner;
  assign m1_ready = (state == IDLE) && m1_valid &&  winner;

  assign m0_rvalid = (state == WAIT) && (cnt == 2'd1) && !port;
  assign m1_rvalid = (state == WAIT) && (cnt == 2'd1) &&  port;
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;

  // The memory-side registers double as the request latch, so the strobes are
  // loaded at acceptance and are therefore visible exactly in the ISSUE cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      port       <= 1'b0;
      cnt        <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wmask  <= '0;
      mem_rstrb  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mem_rstrb <= 1'b0;
          mem_wmask <= '0;
          if (req_any) begin
            port       <= winner;
            last_grant <= winner;
            mem_addr   <= sel_addr;
            mem_wdata  <= sel_wdata;
            if (sel_wmask != '0) mem_wmask <= sel_wmask;
            else                 mem_rstrb <= 1'b1;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          mem_rstrb <= 1'b0;
          mem_wmask <= '0;
          if (mem_wmask != '0) begin
            state <= IDLE;
          end else begin
            cnt   <= LAT_CNT;
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 2'd1;
          if (cnt == 2'd1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
